// File: rtl/punc_fetch_if.sv
// punc_fetch_if
//   Bundles the two handshakes of the PUnC fetch unit:
//     instruction-memory side : mem_req / mem_addr  ->  mem_ack / mem_rdata
//     decode side             : ir_valid / ir_data / ir_pc  ->  ir_ready
//   master : the fetch unit (drives requests and the instruction head)
//   slave  : memory plus consumer (drives ack/rdata and ready)
interface punc_fetch_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;

  modport master (
    output mem_req, mem_addr, ir_valid, ir_data, ir_pc,
    input  mem_ack, mem_rdata, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir_valid, ir_data, ir_pc,
    output mem_ack, mem_rdata, ir_ready
  );
endinterface

// File: rtl/punc_fetch_unit.sv
// punc_fetch_unit
//   Instruction prefetch stage ahead of the PUnC control unit. Issues one read at a
//   time to instruction memory, buffers returned words in a DEPTH-entry FIFO, and
//   presents the head word with its incremented PC (fetch address + 1).
//   A redirect pulse flushes the FIFO and restarts fetch at redirect_pc; a request
//   already in flight is allowed to finish and its data is dropped.
// Ports
//   clk          clock, all state on posedge
//   rst          synchronous active-high reset
//   fetch_en     1 = may issue new requests (in-flight request always completes)
//   redirect     single-cycle flush/refetch pulse
//   redirect_pc  new fetch address
//   bus          punc_fetch_if.master: mem_req/mem_addr/mem_ack/mem_rdata,
//                ir_valid/ir_data/ir_pc/ir_ready
//
//   state  | meaning
//   S_IDLE | no request outstanding; issue when enabled and FIFO has room
//   S_REQ  | mem_req held at mem_addr until mem_ack
module punc_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  punc_fetch_if.master bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  typedef enum logic [0:0] {
    S_IDLE,
    S_REQ
  } state_t;

  state_t      state;
  logic        req_q;
  logic [15:0] addr_q;
  logic [15:0] fetch_pc;
  logic        squash;

  logic [15:0] fifo_data [DEPTH];
  logic [15:0] fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic ack_fire;
  logic push;
  logic pop;
  logic has_room;

  // Ack only counts while a request is actually outstanding.
  assign ack_fire = (state == S_REQ) && bus.mem_ack;
  // A redirect in the ack cycle drops the word just like a pending squash.
  assign push     = ack_fire && !squash && !redirect;
  assign pop      = (count != '0) && bus.ir_ready;
  assign has_room = (count < DEPTH_C);

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign bus.ir_valid = (count != '0);
  assign bus.ir_data  = fifo_data[rd_ptr];
  assign bus.ir_pc    = fifo_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      fetch_pc <= RESET_PC;
      squash   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Skip issue during a redirect so the first request already uses the new PC.
          if (fetch_en && has_room && !redirect) begin
            state  <= S_REQ;
            req_q  <= 1'b1;
            addr_q <= fetch_pc;
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            state  <= S_IDLE;
            req_q  <= 1'b0;
            squash <= 1'b0;
          end else if (redirect) begin
            squash <= 1'b1;
          end
        end
      endcase

      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (ack_fire && !squash) begin
        fetch_pc <= fetch_pc + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data[i] <= 16'h0000;
        fifo_pc[i]   <= 16'h0000;
      end
    end else if (redirect) begin
      // Flush wins over any same-cycle pop or push.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= bus.mem_rdata;
        fifo_pc[wr_ptr]   <= fetch_pc + 16'd1;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_fetch_unit.sv
module tb_punc_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [15:0] redirect_pc;

  punc_fetch_if bus();

  punc_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
  } exp_t;

  typedef struct {
    logic [15:0] start;
    int          delay;
    int          n;
    logic [15:0] first_pc;
    logic [15:0] last_pc;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          ack_delay = 0;
  int          wcnt = 0;
  bit          inject_stale = 0;
  logic [15:0] exp_next;
  logic [15:0] cur_req_addr;
  bit          discard_pending;
  int          issue_cnt;
  bit          issued_now;
  logic [15:0] last_issue_addr;
  int          pop_cnt;
  logic [15:0] first_pop_pc;
  logic [15:0] first_pop_data;
  logic [15:0] last_pop_pc;
  logic [15:0] last_pop_data;

  function automatic logic [15:0] word(input logic [15:0] a);
    return a + 16'hA000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event within budget, expected one (t=%0t)", name, $time);
  endtask

  // One clock: check the pop about to happen, take the edge, update the
  // expectation model, check outputs, then play the memory for the next cycle.
  task automatic tick();
    bit          pre_req, pre_ack, pre_redir, pre_rst;
    logic [15:0] pre_rpc;
    exp_t        e;
    pre_req   = bus.mem_req;
    pre_ack   = bus.mem_req && bus.mem_ack;
    pre_redir = redirect;
    pre_rst   = rst;
    pre_rpc   = redirect_pc;
    if (!rst && bus.ir_valid && bus.ir_ready) begin
      if (exp_q.size() == 0) begin
        timeout_fail("pop_with_empty_scoreboard");
      end else begin
        e = exp_q.pop_front();
        chk("ir_data", bus.ir_data, e.data);
        chk("ir_pc", bus.ir_pc, e.pc);
        if (pop_cnt == 0) begin
          first_pop_pc   = bus.ir_pc;
          first_pop_data = bus.ir_data;
        end
        last_pop_pc   = bus.ir_pc;
        last_pop_data = bus.ir_data;
        pop_cnt++;
      end
    end

    @(posedge clk);
    #1;
    issued_now = 0;
    if (pre_rst) begin
      exp_q.delete();
      exp_next        = RESET_PC;
      discard_pending = 0;
    end else begin
      if (pre_ack) begin
        if (!discard_pending && !pre_redir) begin
          exp_q.push_back('{word(cur_req_addr), cur_req_addr + 16'd1});
          exp_next = cur_req_addr + 16'd1;
        end
        discard_pending = 0;
      end else if (pre_req && pre_redir) begin
        discard_pending = 1;
      end
      if (pre_redir) begin
        exp_q.delete();
        exp_next = pre_rpc;
      end
      if (pre_req && !pre_ack) begin
        chk("req_held", bus.mem_req, 1);
        chk("addr_held", bus.mem_addr, cur_req_addr);
      end else if (!pre_req && bus.mem_req) begin
        issued_now = 1;
        issue_cnt++;
        last_issue_addr = bus.mem_addr;
        chk("issue_addr", bus.mem_addr, exp_next);
        cur_req_addr = exp_next;
      end
    end
    chk("ir_valid", bus.ir_valid, exp_q.size() != 0);

    bus.mem_ack = 1'b0;
    if (inject_stale) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hDEAD;
      inject_stale  = 0;
    end else if (bus.mem_req) begin
      if (wcnt >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = word(bus.mem_addr);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic wait_issue(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (issued_now) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_pops(input string name, input int n, input int budget);
    for (int i = 0; i < budget && pop_cnt < n; i++) tick();
    if (pop_cnt < n) timeout_fail(name);
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect = 1'b0;
    pop_cnt  = 0;
  endtask

  vec_t vecs[4];

  initial begin
    bit hit;
    vecs[0] = '{16'h0000, 0, 4, 16'h0001, 16'h0004};
    vecs[1] = '{16'h0100, 2, 3, 16'h0101, 16'h0103};
    vecs[2] = '{16'hFFFE, 0, 3, 16'hFFFF, 16'h0001};
    vecs[3] = '{16'hFFFF, 1, 2, 16'h0000, 16'h0001};

    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0000; bus.ir_ready = 1'b0;
    exp_next = RESET_PC; cur_req_addr = RESET_PC; discard_pending = 0;
    issue_cnt = 0; pop_cnt = 0;
    first_pop_pc = '0; first_pop_data = '0; last_pop_pc = '0; last_pop_data = '0;
    last_issue_addr = '0;
    tick();
    tick();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, RESET_PC);
    chk("rst_ir_data", bus.ir_data, 16'h0000);
    chk("rst_ir_pc", bus.ir_pc, 16'h0000);
    rst = 1'b0;

    // Streaming vectors, including PC wrap through 16'hFFFF.
    fetch_en = 1'b1;
    bus.ir_ready = 1'b1;
    foreach (vecs[i]) begin
      ack_delay = vecs[i].delay;
      do_redirect(vecs[i].start);
      wait_pops("vec_pops", vecs[i].n, 200);
      chk("vec_first_pc", first_pop_pc, vecs[i].first_pc);
      chk("vec_first_data", first_pop_data, word(vecs[i].start));
      chk("vec_last_pc", last_pop_pc, vecs[i].last_pc);
      chk("vec_last_data", last_pop_data, word(vecs[i].last_pc - 16'd1));
    end

    // Backpressure: FIFO fills with exactly DEPTH requests, then resumes.
    bus.ir_ready = 1'b0;
    ack_delay = 0;
    do_redirect(16'h0000);
    issue_cnt = 0;
    for (int i = 0; i < 30; i++) tick();
    chk("bp_issue_cnt", issue_cnt, 2);
    chk("bp_req_low", bus.mem_req, 0);
    bus.ir_ready = 1'b1;
    wait_issue("bp_resume", 20);
    chk("bp_resume_addr", last_issue_addr, 16'h0002);

    // Redirect while a slow request is outstanding.
    ack_delay = 3;
    do_redirect(16'h0002);
    wait_issue("sq_issue", 20);
    chk("sq_first_addr", last_issue_addr, 16'h0002);
    do_redirect(16'h3000);
    wait_issue("sq_reissue", 30);
    chk("sq_reissue_addr", last_issue_addr, 16'h3000);
    wait_pops("sq_pop", 1, 30);
    chk("sq_first_pc", first_pop_pc, 16'h3001);
    chk("sq_first_data", first_pop_data, word(16'h3000));

    // Redirect in the same cycle as mem_ack and a pop.
    ack_delay = 0;
    bus.ir_ready = 1'b0;
    do_redirect(16'h0200);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      tick();
      if (bus.mem_ack && bus.mem_req && bus.ir_valid) hit = 1;
    end
    if (!hit) timeout_fail("ack_pop_setup");
    redirect = 1'b1;
    redirect_pc = 16'h4000;
    bus.ir_ready = 1'b1;
    tick();
    redirect = 1'b0;
    pop_cnt = 0;
    chk("ack_pop_flushed", bus.ir_valid, 0);
    wait_issue("ack_pop_reissue", 20);
    chk("ack_pop_reissue_addr", last_issue_addr, 16'h4000);
    wait_pops("ack_pop_pop", 1, 20);
    chk("ack_pop_first_pc", first_pop_pc, 16'h4001);

    // Reset mid-request, stale ack, fetch_en gating.
    ack_delay = 3;
    do_redirect(16'h0500);
    wait_issue("rst_setup", 20);
    rst = 1'b1;
    fetch_en = 1'b0;
    tick();
    chk("rst_mid_req_drop", bus.mem_req, 0);
    rst = 1'b0;
    issue_cnt = 0;
    inject_stale = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_no_issue", issue_cnt, 0);
    chk("rst_stale_ignored", bus.ir_valid, 0);
    fetch_en = 1'b1;
    wait_issue("rst_reissue", 20);
    chk("rst_reissue_addr", last_issue_addr, RESET_PC);
    wait_pops("rst_pop", 1, 20);
    chk("rst_first_pc", first_pop_pc, RESET_PC + 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
